// File: rtl/clock_reset_ctrl.sv
// Board-side front end for the turtle CPU core.
// Conditions the raw reset button, mode switch and step button. Sequences
// the core reset through assert, hold and release. Issues the core clock
// enable: divided free-running steps in auto mode, or exactly one step per
// accepted press in manual mode. Also counts steps since the last release.
module clock_reset_ctrl #(
  parameter int CLK_PERIOD_NS     = 100,
  parameter int DEBOUNCE_NS       = 1000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int AUTO_DIV          = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reset_btn,
  input  logic        manual_clk_sw,
  input  logic        pulse_clk_btn,
  output logic        cpu_rst_n,
  output logic        cpu_clk_en,
  output logic        manual_mode,
  output logic [15:0] step_count
);

  localparam int DEBOUNCE_RAW    = DEBOUNCE_NS / CLK_PERIOD_NS;
  localparam int DEBOUNCE_CYCLES = (DEBOUNCE_RAW > 1) ? DEBOUNCE_RAW : 1;
  localparam int DB_W            = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W           = ($clog2(AUTO_DIV) > 0) ? $clog2(AUTO_DIV) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(AUTO_DIV - 1);
  localparam logic [15:0]      HOLD_LAST = 16'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    RST_ASSERT = 2'd0,
    RST_HOLD   = 2'd1,
    RUN        = 2'd2
  } state_t;

  // Bit 0: reset button, bit 1: mode switch, bit 2: step button.
  logic [2:0]      raw;
  logic [2:0]      sync_p0;
  logic [2:0]      sync_p1;
  logic [2:0]      deb;
  logic [DB_W-1:0] db_cnt [3];

  logic            rst_deb;
  logic            mode_deb;
  logic            pulse_deb;
  logic            pulse_prev;
  logic            step_rise;
  logic            mode_change;

  state_t          state;
  logic [15:0]     hold_cnt;
  logic [DIV_W-1:0] div_cnt;

  assign raw         = {pulse_clk_btn, manual_clk_sw, reset_btn};
  assign rst_deb     = deb[0];
  assign mode_deb    = deb[1];
  assign pulse_deb   = deb[2];
  assign step_rise   = pulse_deb & ~pulse_prev;
  assign mode_change = mode_deb ^ manual_mode;

  // Two-flop synchronizer for all raw board inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Per-input debouncer: accept a new level only after it has been seen
  // for DEBOUNCE_CYCLES consecutive cycles; any matching cycle restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Reset sequencer and step-enable generation with registered outputs.
  // The enable is computed from the same decision that moves the state, so
  // it can never be high in a cycle where cpu_rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_ASSERT;
      hold_cnt    <= '0;
      div_cnt     <= '0;
      cpu_rst_n   <= 1'b0;
      cpu_clk_en  <= 1'b0;
      manual_mode <= 1'b0;
      pulse_prev  <= 1'b0;
    end else begin
      // History and mode track the debounced inputs in every state.
      pulse_prev  <= pulse_deb;
      manual_mode <= mode_deb;
      cpu_clk_en  <= 1'b0;
      case (state)
        RST_ASSERT: begin
          cpu_rst_n <= 1'b0;
          hold_cnt  <= '0;
          div_cnt   <= '0;
          if (!rst_deb) begin
            state <= RST_HOLD;
          end
        end
        RST_HOLD: begin
          cpu_rst_n <= 1'b0;
          div_cnt   <= '0;
          if (rst_deb) begin
            state    <= RST_ASSERT;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        RUN: begin
          if (rst_deb) begin
            // Reset wins over any step decided in this cycle.
            state     <= RST_ASSERT;
            cpu_rst_n <= 1'b0;
            div_cnt   <= '0;
          end else if (mode_change) begin
            // Mode switch: no step, divider restarts, pending edge dropped.
            div_cnt <= '0;
          end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            if (manual_mode) begin
              cpu_clk_en <= step_rise;
            end else begin
              cpu_clk_en <= (div_cnt == '0);
            end
          end
        end
        default: begin
          state     <= RST_ASSERT;
          cpu_rst_n <= 1'b0;
          hold_cnt  <= '0;
          div_cnt   <= '0;
        end
      endcase
    end
  end

  // Step counter: held at zero during core reset, wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count <= '0;
    end else if (!cpu_rst_n) begin
      step_count <= '0;
    end else if (cpu_clk_en) begin
      step_count <= step_count + 16'd1;
    end
  end

endmodule

// File: doc/clock_reset_ctrl.md
Name: clock_reset_ctrl

Overview:
- Front-end controller between the board buttons/switch and the turtle CPU core.
- Synchronizes and debounces `reset_btn`, `manual_clk_sw` and `pulse_clk_btn`.
- Sequences the core reset: assert, hold, release.
- Issues the core's clock enable: free-running divided stepping in auto mode, or exactly one cycle per button press in manual mode.
- Instantiated in `turtle_cpu_top`. The CPU core runs on `clk` and advances only when `cpu_clk_en` is high.

Parameters:
- `CLK_PERIOD_NS`, 100, period of `clk` in ns. Used to derive debounce length.
- `DEBOUNCE_NS`, 1000, minimum stable time for any input to be accepted. `DEBOUNCE_CYCLES = max(1, DEBOUNCE_NS / CLK_PERIOD_NS)`.
- `RESET_HOLD_CYCLES`, 16, cycles `cpu_rst_n` stays low after the debounced reset button releases. Legal range 1 to 65535.
- `AUTO_DIV`, 1, auto-mode step divider. `cpu_clk_en` is high 1 cycle in every `AUTO_DIV`. Value 1 means always high.

Ports:
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `reset_btn`  input  1  raw reset push-button, active high, asynchronous to `clk`.
- `manual_clk_sw`  input  1  raw mode switch. 1 = manual stepping, 0 = auto.
- `pulse_clk_btn`  input  1  raw step push-button, active high.
- `cpu_rst_n`  output  1  registered active-low reset to the CPU core.
- `cpu_clk_en`  output  1  registered single-cycle step enable to the CPU core.
- `manual_mode`  output  1  registered debounced mode currently in effect.
- `step_count`  output  16  number of `cpu_clk_en` pulses since the last release of `cpu_rst_n`.

Behaviour:
- **Async reset** (`rst_n` = 0):
  - All flops clear.
  - Outputs: `cpu_rst_n` = 0, `cpu_clk_en` = 0, `manual_mode` = 0, `step_count` = 0.
  - Debounced values = 0. FSM = `RST_ASSERT`.
- **Input conditioning:**
  - Each raw input passes through a 2-flop synchronizer, then its own debouncer.
  - The debouncer counter increments while the synchronized value differs from the debounced value. It clears to 0 on any cycle they match.
  - The debounced value flips on the edge at which the counter reaches `DEBOUNCE_CYCLES - 1`. The counter then clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- **Reset FSM:**
  - `RST_ASSERT`: `cpu_rst_n` = 0. Go to `RST_HOLD` when debounced `reset_btn` = 0.
  - `RST_HOLD`: `cpu_rst_n` = 0. Hold counter counts up from 0. Go to `RUN` on the edge where the count reaches `RESET_HOLD_CYCLES - 1`. Return to `RST_ASSERT` if debounced `reset_btn` = 1 at any time.
  - `RUN`: `cpu_rst_n` = 1, registered, high from the first `RUN` cycle. Go to `RST_ASSERT` when debounced `reset_btn` = 1. `cpu_rst_n` falls on the next edge.
  - Out of `rst_n`, the button is debounced low, so `RST_ASSERT` exits after 1 cycle. First `RUN` cycle follows `RESET_HOLD_CYCLES` cycles of `RST_HOLD`.
- **Step enable** (only in `RUN`; 0 in all other states):
  - Auto mode (`manual_mode` = 0):
    - Divider counter runs 0 to `AUTO_DIV - 1` and wraps.
    - `cpu_clk_en` = 1 in the cycle after the counter equals 0.
    - First pulse is in the 2nd `RUN` cycle, every `AUTO_DIV` cycles thereafter.
  - Manual mode (`manual_mode` = 1):
    - `cpu_clk_en` = 1 for exactly one cycle, the cycle after a rising edge of debounced `pulse_clk_btn`.
    - Holding the button gives no further pulses. Total latency from the first edge sampling raw button = 1 to `cpu_clk_en` high is `3 + DEBOUNCE_CYCLES` edges.
  - Step button edges in auto mode are ignored. The edge-detector history keeps updating in every mode, so switching to manual with the button already held does not step.
- **Mode change:**
  - `manual_mode` follows debounced `manual_clk_sw` with 1 register.
  - In the cycle `manual_mode` changes, `cpu_clk_en` = 0, the divider clears to 0 and any pending manual edge is dropped.
- **`step_count`:**
  - Clears while `cpu_rst_n` = 0.
  - Increments by 1 on each cycle `cpu_clk_en` = 1. Wraps 0xFFFF → 0x0000.
- **Simultaneous events:**
  - A reset button asserting in the same cycle as a step edge: reset wins, no step, `cpu_clk_en` = 0.
  - A mode change in the same cycle as a step edge: no step.
- Exactly one `cpu_clk_en` pulse per accepted press. `cpu_clk_en` never asserts while `cpu_rst_n` = 0.

Test Plan:
All scenarios use `CLK_PERIOD_NS`=100, `DEBOUNCE_NS`=1000 (`DEBOUNCE_CYCLES`=10), `RESET_HOLD_CYCLES`=16, `AUTO_DIV`=4.
1. Release `rst_n`, all buttons 0 → `cpu_rst_n` = 0 for exactly 17 cycles, then 1. First `cpu_clk_en` in the 2nd `RUN` cycle, then every 4 cycles. `step_count` = 5 after 5 pulses.
2. `reset_btn` high for 500 ns (5 cycles) while in `RUN` → no effect. `reset_btn` high for 2000 ns → `cpu_rst_n` falls 13 edges after assertion. `step_count` = 0. Release → 16 hold cycles, then `RUN`.
3. Manual mode, `pulse_clk_btn` high for 1500 ns, 10 times with 1500 ns gaps → exactly 10 single-cycle `cpu_clk_en` pulses. `step_count` increases by 10. Each pulse comes 13 edges after its press.
4. Manual mode, `pulse_clk_btn` high for 10 ns, and high/low for 50 ns alternating → zero `cpu_clk_en` pulses, `step_count` unchanged.
5. Hold `pulse_clk_btn` high in auto mode, then switch to manual → no step on the switch. `cpu_clk_en` = 0 in the `manual_mode` change cycle. Next release-and-press → 1 step. Switch back to auto → divider restarts from 0.
6. Force `step_count` to 0xFFFF via 65535 auto steps, then 1 more step → 0x0000. Assert `rst_n` = 0 mid-`RUN` → all outputs 0 immediately, without waiting for a clock edge.
